debug_mailbox: RTL and testbench
================================

# debug_mailbox

Synthesizable, parametrised debug mailbox on the data-memory bus, replacing the plain debug RAM. The core writes argument words, then a function code to word 0. Each function write snapshots the code plus all argument words into a command FIFO, drained by a bench, serial bridge or host monitor over a valid/ready handshake. The block adds read-back status, overflow detection and a halt flag, none of which the plain debug RAM provides.

## Interface
- ARG_COUNT, 8: words in the argument file, word 0 is the function register; power of two, 2..32
- FIFO_DEPTH, 4: command FIFO entries; power of two, 2..16
- AW, $clog2(ARG_COUNT)+1: address width, word-addressed
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- we  in  1  bus write enable
- addr  in  AW  word address
- wd  in  32  write data
- rd  out  32  combinational read data
- cmd_valid  out  1  FIFO head holds a command
- cmd_ready  in  1  consumer accepts head this cycle
- cmd_func  out  32  head function code
- cmd_args  out  32*ARG_COUNT  head snapshot, word i at [32*i +: 32], word 0 == cmd_func
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- overflow  out  1  sticky: a command was dropped
- halted  out  1  an exit command has been consumed

## Operation
- Argument file: `addr < ARG_COUNT` with `we` writes word `addr`.
- Push: a write to addr 0 creates snapshot `{wd, args[1..ARG_COUNT-1]}`, using the pre-edge argument values.
- Status register at `addr == ARG_COUNT`:
  - read: `{16'b0, level zero-extended to 8 bits, 6'b0, halted, overflow}`
  - write with `wd[0]=1` clears `overflow`; other bits are ignored
- Addresses above ARG_COUNT: writes ignored, reads 0. For `addr < ARG_COUNT`, `rd` returns the argument word.
- Pop: occurs when `cmd_valid & cmd_ready`.
- Full FIFO:
  - push with a simultaneous pop is accepted
  - push without a pop is dropped, FIFO unchanged, `overflow` set
- Empty FIFO: `cmd_ready` is ignored and `cmd_outputs` are don't-care, bench checks gated by `cmd_valid`.
- Push into an empty FIFO with `cmd_ready` high: no bypass, the entry pops no earlier than the next cycle.
- `halted` sets on a pop whose `cmd_func == 0` (FN_EXIT). Only reset clears it. Writes and pushes continue while halted.
- The block does not interpret any code other than FN_EXIT. All codes pass through unchanged.
- Pointers wrap modulo FIFO_DEPTH. `level` is in 0..FIFO_DEPTH.

## Timing
- Reset (async assert, sync-safe deassert): argument file 0, FIFO empty, `cmd_valid=0`, `level=0`, `overflow=0`, `halted=0`.
- Push at edge k: `cmd_valid` and `level` update after edge k. Head data is stable from edge k until the pop edge.
- Pop at edge k: the next entry is presented after edge k.
- `overflow` and `halted` are registered, visible the cycle after the causing edge.
- `rd` is combinational from `addr` and registered state. A same-cycle write is not forwarded.
- Reset mid-operation discards all FIFO contents immediately.

## Structure
- Package `debug_mailbox_pkg`:
  - function codes: FN_EXIT=0, FN_ASSERT_EQ=1, FN_ASSERT_NE=2, FN_PUTS=3, FN_CHECK_REGS=32'h0001_0000, FN_DUMP=32'hffff_0000
  - status bit positions
  - snapshot struct typedef
- Sub-module `debug_cmd_fifo`: synchronous FIFO, parametrised width and depth, with push, pop, full, empty and level.
- The top level holds the argument file, address decode, status register and halt logic.

## Test plan
- Reset, then read addr 0..ARG_COUNT → all 0. `cmd_valid=0`. Status reads 0.
- Write args[1]=5, args[2]=5, then addr0=1 with `cmd_ready=0` → next cycle `cmd_valid=1`, `cmd_func=1`, args[1]=args[2]=5, `level=1`. Pop → `level=0`.
- With `cmd_ready=0`, issue FIFO_DEPTH+1 function writes (codes 3,3,3,3,2) → `level=4`, `overflow=1`, head code 3. Write status with wd=1 → `overflow=0`, `level` still 4.
- FIFO full with `cmd_ready=1` and a simultaneous function write → push accepted, `level` stays 4, `overflow` stays 0.
- Push code 0, then pop → `halted=1` next cycle. Further pushes are still accepted. Status bit 1 reads 1.
- Drop `reset` low asynchronously while `level=3` → `cmd_valid`, `level`, `halted` and `overflow` go 0 without a clock edge.

Source files
------------

// File: rtl/debug_mailbox_pkg.sv
// Shared types and constants for the debug mailbox: function codes, status
// register layout and the word type used by the argument file and snapshots.
package debug_mailbox_pkg;

    typedef logic [31:0] word_t;

    localparam word_t FN_EXIT       = 32'h0000_0000;
    localparam word_t FN_ASSERT_EQ  = 32'h0000_0001;
    localparam word_t FN_ASSERT_NE  = 32'h0000_0002;
    localparam word_t FN_PUTS       = 32'h0000_0003;
    localparam word_t FN_CHECK_REGS = 32'h0001_0000;
    localparam word_t FN_DUMP       = 32'hffff_0000;

    localparam int STATUS_OVERFLOW_BIT = 0;
    localparam int STATUS_HALTED_BIT   = 1;
    localparam int STATUS_LEVEL_LSB    = 8;
    localparam int STATUS_LEVEL_W      = 8;

    // Field order mirrors the bit positions above, MSB first.
    typedef struct packed {
        logic [15:0] reserved_hi;
        logic [7:0]  level;
        logic [5:0]  reserved_lo;
        logic        halted;
        logic        overflow;
    } status_t;

    function automatic word_t pack_status(input logic [7:0] level,
                                          input logic       halted,
                                          input logic       overflow);
        status_t s;
        s             = '0;
        s.level       = level;
        s.halted      = halted;
        s.overflow    = overflow;
        return word_t'(s);
    endfunction

endpackage

// File: rtl/debug_cmd_fifo.sv
// Synchronous command FIFO: registered head, power-of-two depth, a push into a
// full FIFO is accepted only when a pop happens on the same edge.
module debug_cmd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];
    assign level   = count;

    // NOTE: storage has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/debug_mailbox.sv
// Debug mailbox on the data-memory bus: argument file, function-write snapshot
// into a command FIFO, status register with sticky overflow and a halt flag.
module debug_mailbox
    import debug_mailbox_pkg::*;
#(
    parameter int ARG_COUNT  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int AW         = $clog2(ARG_COUNT) + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          we,
    input  logic [AW-1:0]                 addr,
    input  logic [31:0]                   wd,
    output logic [31:0]                   rd,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [31:0]                   cmd_func,
    output logic [32*ARG_COUNT-1:0]       cmd_args,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          halted
);

    localparam int IW = $clog2(ARG_COUNT);
    localparam logic [AW-1:0] STATUS_ADDR = AW'(ARG_COUNT);

    typedef word_t [ARG_COUNT-1:0] snapshot_t;

    word_t        args [ARG_COUNT];
    snapshot_t    push_snap;
    snapshot_t    head_snap;
    logic         arg_sel;
    logic         status_sel;
    logic [IW-1:0] arg_idx;
    logic         push;
    logic         pop_fire;
    logic         fifo_full;
    logic         fifo_empty;

    assign arg_sel    = (addr < STATUS_ADDR);
    assign status_sel = (addr == STATUS_ADDR);
    assign arg_idx    = addr[IW-1:0];
    assign push       = we && (addr == '0);
    assign pop_fire   = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ARG_COUNT; i++) args[i] <= '0;
        end else if (we && arg_sel) begin
            args[arg_idx] <= wd;
        end
    end

    // The snapshot takes the new function code but the pre-edge arguments.
    always_comb begin
        push_snap    = '0;
        push_snap[0] = wd;
        for (int i = 1; i < ARG_COUNT; i++) push_snap[i] = args[i];
    end

    debug_cmd_fifo #(
        .WIDTH (32 * ARG_COUNT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_snap),
        .pop       (cmd_ready),
        .head      (head_snap),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    assign cmd_valid = !fifo_empty;
    assign cmd_args  = head_snap;
    assign cmd_func  = head_snap[0];

    // Overflow and its clear are address-exclusive, so they never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop_fire) begin
            overflow <= 1'b1;
        end else if (we && status_sel && wd[STATUS_OVERFLOW_BIT]) begin
            overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted <= 1'b0;
        end else if (pop_fire && (cmd_func == FN_EXIT)) begin
            halted <= 1'b1;
        end
    end

    // NOTE: rd gets a default before any branch so no latch is inferred.
    always_comb begin
        rd = '0;
        if (arg_sel) begin
            rd = args[arg_idx];
        end else if (status_sel) begin
            rd = pack_status(STATUS_LEVEL_W'(level), halted, overflow);
        end
    end

endmodule

// File: tb/tb_debug_mailbox.sv
// Self-checking bench for debug_mailbox: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_debug_mailbox;

    localparam int AC    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(AC) + 1;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int CW    = 32 * AC;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   wd = '0;
    logic          cmd_ready = 1'b0;
    logic [31:0]   rd;
    logic          cmd_valid;
    logic [31:0]   cmd_func;
    logic [CW-1:0] cmd_args;
    logic [LW-1:0] level;
    logic          overflow;
    logic          halted;

    int checks = 0;
    int failures = 0;
    bit started = 0;

    debug_mailbox #(.ARG_COUNT(AC), .FIFO_DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .addr      (addr),
        .wd        (wd),
        .rd        (rd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_func  (cmd_func),
        .cmd_args  (cmd_args),
        .level     (level),
        .overflow  (overflow),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    // Reference model: argument array, queue of snapshots, two flags.
    logic [31:0]   m_args [AC];
    logic [CW-1:0] m_q [$];
    bit            m_ovf = 0;
    bit            m_halt = 0;
    logic [CW-1:0] m_snap;
    bit            m_pop;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < AC; i++) m_args[i] = '0;
            m_q.delete();
            m_ovf  = 0;
            m_halt = 0;
        end else begin
            m_pop = (m_q.size() > 0) && cmd_ready;
            m_snap = '0;
            for (int i = 1; i < AC; i++) m_snap[32*i +: 32] = m_args[i];
            m_snap[31:0] = wd;
            if (m_pop) begin
                if (m_q[0][31:0] == 32'd0) m_halt = 1;
                void'(m_q.pop_front());
            end
            if (we && addr == 0) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_snap);
                else m_ovf = 1;
            end
            if (we && addr == AW'(AC) && wd[0]) m_ovf = 0;
            if (we && addr < AW'(AC)) m_args[addr] = wd;
        end
    end

    function automatic logic [31:0] model_rd(input logic [AW-1:0] a);
        if (a < AW'(AC)) return m_args[a];
        if (a == AW'(AC)) return {16'd0, 8'(m_q.size()), 6'd0, m_halt, m_ovf};
        return 32'd0;
    endfunction

    task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("cmd_valid", CW'(cmd_valid), CW'(m_q.size() != 0));
            check("level", CW'(level), CW'(m_q.size()));
            check("overflow", CW'(overflow), CW'(m_ovf));
            check("halted", CW'(halted), CW'(m_halt));
            check("rd", CW'(rd), CW'(model_rd(addr)));
            if (m_q.size() != 0) begin
                check("cmd_func", CW'(cmd_func), CW'(m_q[0][31:0]));
                check("cmd_args", cmd_args, m_q[0]);
            end
        end
    end

    task automatic drive(input logic w, input logic [AW-1:0] a, input logic [31:0] d, input logic r);
        we = w;
        addr = a;
        wd = d;
        cmd_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [AW-1:0] a, input logic [31:0] exp, input string name);
        drive(1'b0, a, 32'd0, 1'b0);
        check(name, CW'(rd), CW'(exp));
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [31:0]   rw;
        int            sel;

        #1 started = 1;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;

        // Reset state.
        for (int i = 0; i <= AC; i++) peek(AW'(i), 32'd0, "reset_rd");
        check("reset_valid", CW'(cmd_valid), '0);

        // Single command with two equal arguments.
        drive(1'b1, AW'(1), 32'd5, 1'b0);
        drive(1'b1, AW'(2), 32'd5, 1'b0);
        drive(1'b1, AW'(0), 32'd1, 1'b0);
        check("t2_valid", CW'(cmd_valid), CW'(1));
        check("t2_func", CW'(cmd_func), CW'(1));
        check("t2_arg1", CW'(cmd_args[63:32]), CW'(5));
        check("t2_arg2", CW'(cmd_args[95:64]), CW'(5));
        check("t2_level", CW'(level), CW'(1));
        drive(1'b0, AW'(0), 32'd0, 1'b1);
        check("t2_pop_level", CW'(level), CW'(0));

        // Overflow on the fifth push, then clear via status.
        drive(1'b1, AW'(0), 32'd3, 1'b0);
        drive(1'b1, AW'(0), 32'd3, 1'b0);
        drive(1'b1, AW'(0), 32'd3, 1'b0);
        drive(1'b1, AW'(0), 32'd3, 1'b0);
        drive(1'b1, AW'(0), 32'd2, 1'b0);
        check("t3_level", CW'(level), CW'(4));
        check("t3_overflow", CW'(overflow), CW'(1));
        check("t3_func", CW'(cmd_func), CW'(3));
        peek(AW'(AC), 32'h0000_0401, "t3_status");
        drive(1'b1, AW'(AC), 32'd1, 1'b0);
        check("t3_clear", CW'(overflow), CW'(0));
        check("t3_level_kept", CW'(level), CW'(4));

        // Full FIFO with simultaneous pop and push.
        drive(1'b1, AW'(0), 32'd7, 1'b1);
        check("t4_level", CW'(level), CW'(4));
        check("t4_overflow", CW'(overflow), CW'(0));
        check("t4_func", CW'(cmd_func), CW'(3));

        // Drain, then exit command sets halted.
        repeat (4) drive(1'b0, AW'(0), 32'd0, 1'b1);
        check("t5_drained", CW'(level), CW'(0));
        drive(1'b1, AW'(0), 32'd0, 1'b0);
        drive(1'b0, AW'(0), 32'd0, 1'b1);
        check("t5_halted", CW'(halted), CW'(1));
        peek(AW'(AC), 32'h0000_0002, "t5_status");
        drive(1'b1, AW'(0), 32'd5, 1'b0);
        check("t5_push_after_halt", CW'(level), CW'(1));
        drive(1'b1, AW'(0), 32'd6, 1'b0);
        drive(1'b1, AW'(0), 32'd9, 1'b0);
        check("t6_level3", CW'(level), CW'(3));

        // Asynchronous reset with no clock edge.
        #2 reset = 1'b0;
        we = 1'b0;
        cmd_ready = 1'b0;
        #1;
        check("t6_valid", CW'(cmd_valid), '0);
        check("t6_level", CW'(level), '0);
        check("t6_halted", CW'(halted), '0);
        check("t6_overflow", CW'(overflow), '0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;

        // Randomised traffic.
        for (int n = 0; n < 2000; n++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 35) ra = AW'(0);
            else if (sel < 80) ra = AW'($urandom_range(1, AC - 1));
            else if (sel < 92) ra = AW'(AC);
            else ra = AW'($urandom_range(AC + 1, (1 << AW) - 1));
            if (ra == 0) rw = ($urandom_range(0, 49) == 0) ? 32'd0 : 32'($urandom_range(1, 5));
            else rw = $urandom;
            drive(1'($urandom_range(0, 1)), ra, rw, ($urandom_range(0, 9) < 3));
        end

        drive(1'b0, AW'(0), 32'd0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
